// File: rtl/spi_flash_wr_seq.sv
// spi_flash_wr_seq: WREN/PAGE-PROGRAM/RDSR-poll sequencer for spi_drive; define SPI_SEQ_TIMEOUT_EN to bound RDSR polls by POLL_MAX
module spi_flash_wr_seq #(
  parameter int          CS_GAP   = 4,
  parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req,
  input  logic [23:0] addr,
  input  logic [8:0]  len,
  input  logic [7:0]  wr_data,
  output logic        wr_data_rd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        spi_start,
  output logic        spi_end,
  output logic [7:0]  data_send,
  input  logic        send_done,
  input  logic [7:0]  data_rec,
  input  logic        rec_done
);
  typedef enum logic [2:0] {IDLE, WREN, GAP_A, PROG, GAP_B, RDSR, GAP_C, FIN} state_t;
  state_t      state_q;
  logic [23:0] addr_q;
  logic [8:0]  len_q;
  logic [8:0]  cnt_q;
  logic [1:0]  idx_q;
  logic        dat_q;
  logic        rc_q;
  logic        wip_q;
  logic [15:0] gap_q;
  logic        rd_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        start_q;
  logic        end_q;
  logic [7:0]  send_q;
`ifdef SPI_SEQ_TIMEOUT_EN
  logic [15:0] poll_q;
  logic        to_q;
`endif
  logic        bad;
  logic        gap_end;
  logic [7:0]  hdr_byte;
  logic        unused_ok;
  assign bad        = len == 9'd0 || ({2'b00, addr[7:0]} + {1'b0, len}) > 10'd256;
  assign gap_end    = gap_q == 16'(CS_GAP - 1);
  assign hdr_byte   = idx_q == 2'd0 ? addr_q[23:16] : idx_q == 2'd1 ? addr_q[15:8] : addr_q[7:0];
  assign unused_ok  = ^{data_rec[7:1], POLL_MAX[0]};
  assign wr_data_rd = rd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign spi_start  = start_q;
  assign spi_end    = end_q;
  assign data_send  = send_q;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      dat_q   <= 1'b0;
      rc_q    <= 1'b0;
      wip_q   <= 1'b0;
      gap_q   <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      send_q  <= 8'h00;
`ifdef SPI_SEQ_TIMEOUT_EN
      poll_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      rd_q    <= 1'b0;
      case (state_q)
        IDLE: if (req) begin
          if (bad) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            addr_q  <= addr;
            len_q   <= len;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            send_q  <= 8'h06;
            state_q <= WREN;
`ifdef SPI_SEQ_TIMEOUT_EN
            to_q    <= 1'b0;
`endif
          end
        end
        WREN: if (send_done) begin
          end_q   <= 1'b1;
          gap_q   <= '0;
          state_q <= GAP_A;
        end
        GAP_A: begin
          gap_q <= gap_q + 16'd1;
          if (gap_end) begin
            start_q <= 1'b1;
            send_q  <= 8'h02;
            idx_q   <= '0;
            dat_q   <= 1'b0;
            state_q <= PROG;
          end
        end
        PROG: if (send_done) begin
          if (dat_q && cnt_q == len_q) begin
            end_q   <= 1'b1;
            gap_q   <= '0;
            state_q <= GAP_B;
          end else if (dat_q || idx_q == 2'd3) begin
            send_q <= wr_data;
            rd_q   <= 1'b1;
            cnt_q  <= dat_q ? cnt_q + 9'd1 : 9'd1;
            dat_q  <= 1'b1;
          end else begin
            send_q <= hdr_byte;
            idx_q  <= idx_q + 2'd1;
          end
        end
        GAP_B: begin
          gap_q <= gap_q + 16'd1;
          if (gap_end) begin
            start_q <= 1'b1;
            send_q  <= 8'h05;
            idx_q   <= '0;
            rc_q    <= 1'b0;
            state_q <= RDSR;
`ifdef SPI_SEQ_TIMEOUT_EN
            poll_q  <= 16'd1;
`endif
          end
        end
        RDSR: begin
          if (send_done) begin
            if (idx_q[0]) begin
              end_q   <= 1'b1;
              gap_q   <= '0;
              state_q <= GAP_C;
            end else begin
              send_q <= 8'h00;
              idx_q  <= 2'd1;
            end
          end
          if (rec_done) begin
            if (rc_q) wip_q <= data_rec[0];
            rc_q <= 1'b1;
          end
        end
        GAP_C: begin
          gap_q <= gap_q + 16'd1;
          if (gap_end) begin
            if (!wip_q) state_q <= FIN;
`ifdef SPI_SEQ_TIMEOUT_EN
            else if (poll_q == POLL_MAX) begin
              to_q    <= 1'b1;
              state_q <= FIN;
            end
`endif
            else begin
              start_q <= 1'b1;
              send_q  <= 8'h05;
              idx_q   <= '0;
              rc_q    <= 1'b0;
              state_q <= RDSR;
`ifdef SPI_SEQ_TIMEOUT_EN
              poll_q  <= poll_q + 16'd1;
`endif
            end
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef SPI_SEQ_TIMEOUT_EN
          err_q   <= to_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_wr_seq.sv
// tb_spi_flash_wr_seq: randomized transaction-level checks of spi_flash_wr_seq against a byte-stream flash model
module tb_spi_flash_wr_seq;
  localparam int CS_GAP = 4;
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam logic [15:0] PM = 16'd3;
`else
  localparam logic [15:0] PM = 16'hFFFF;
`endif
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        req = 1'b0;
  logic [23:0] addr = '0;
  logic [8:0]  len = '0;
  logic [7:0]  wr_data;
  logic        wr_data_rd, busy, done, err, spi_start, spi_end;
  logic [7:0]  data_send;
  logic        send_done = 1'b0;
  logic [7:0]  data_rec = '0;
  logic        rec_done = 1'b0;
  logic [7:0]  mem [4096];
  logic [11:0] rd_idx = '0;
  logic [7:0]  first_b = '0;
  logic [7:0]  got_b[$];
  int          got_len[$];
  int checks = 0, errors = 0;
  int cyc = 0, last_end = -1000, gap_bad = 0, pops = 0, nwip = 0, poll_n = 0, nb = 0, dly = 0, starts = 0;
  bit tx_on = 1'b0;
  spi_flash_wr_seq #(.CS_GAP(CS_GAP), .POLL_MAX(PM)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .addr(addr), .len(len),
    .wr_data(wr_data), .wr_data_rd(wr_data_rd), .busy(busy), .done(done), .err(err),
    .spi_start(spi_start), .spi_end(spi_end), .data_send(data_send),
    .send_done(send_done), .data_rec(data_rec), .rec_done(rec_done)
  );
  always #10 sys_clk = ~sys_clk;
  assign wr_data = mem[rd_idx];
  always @(posedge sys_clk) if (wr_data_rd) rd_idx <= rd_idx + 12'd1;
  always @(negedge sys_clk) begin
    cyc++;
    send_done = 1'b0;
    rec_done = 1'b0;
    if (wr_data_rd) pops++;
    if (sys_rst) tx_on = 1'b0;
    else begin
      if (spi_end) begin
        tx_on = 1'b0;
        got_len.push_back(nb);
        last_end = cyc;
      end
      if (spi_start) begin
        if (cyc - last_end < CS_GAP) gap_bad++;
        starts++;
        tx_on = 1'b1;
        nb = 0;
        dly = $urandom_range(0, 2);
      end else if (tx_on) begin
        if (dly == 0) begin
          if (nb == 0) first_b = data_send;
          got_b.push_back(data_send);
          data_rec = 8'($urandom);
          if (nb == 1 && first_b == 8'h05) begin
            data_rec[0] = poll_n < nwip;
            poll_n++;
          end
          send_done = 1'b1;
          rec_done = 1'b1;
          nb++;
          dly = $urandom_range(1, 3);
        end else dly--;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic pulse_rst();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask
  task automatic run_req(input logic [23:0] a, input logic [8:0] n, input int w);
    logic [7:0] exp_b[$];
    int exp_len[$];
    int base, np, t;
    logic exp_err;
    base = int'(rd_idx);
    np = w + 1;
    exp_err = 1'b0;
    if (np > int'(PM)) begin
      np = int'(PM);
      exp_err = 1'b1;
    end
    exp_b.push_back(8'h06);
    exp_len.push_back(1);
    exp_b.push_back(8'h02);
    exp_b.push_back(a[23:16]);
    exp_b.push_back(a[15:8]);
    exp_b.push_back(a[7:0]);
    for (int k = 0; k < int'(n); k++) exp_b.push_back(mem[12'(base + k)]);
    exp_len.push_back(int'(n) + 4);
    for (int k = 0; k < np; k++) begin
      exp_b.push_back(8'h05);
      exp_b.push_back(8'h00);
      exp_len.push_back(2);
    end
    got_b.delete();
    got_len.delete();
    pops = 0;
    poll_n = 0;
    nwip = w;
    gap_bad = 0;
    @(negedge sys_clk);
    addr = a;
    len = n;
    req = 1'b1;
    @(negedge sys_clk);
    req = 1'b0;
    for (t = 0; t < 20000 && !done; t++) begin
      if (t == 20) begin
        chk("busy_mid", busy, 1);
        addr = ~a;
        len = 9'd1;
        req = 1'b1;
      end else req = 1'b0;
      @(negedge sys_clk);
    end
    req = 1'b0;
    chk("done_seen", done, 1);
    if (!done) pulse_rst();
    else begin
      chk("err", err, exp_err);
      @(negedge sys_clk);
      chk("done_pulse", done, 0);
      chk("busy_after", busy, 0);
    end
    repeat (3) @(negedge sys_clk);
    chk("n_tx", got_len.size(), exp_len.size());
    for (int i = 0; i < exp_len.size() && i < got_len.size(); i++) chk($sformatf("tx%0d_len", i), got_len[i], exp_len[i]);
    chk("n_bytes", got_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) chk($sformatf("byte%0d", i), {24'd0, got_b[i]}, {24'd0, exp_b[i]});
    chk("pops", pops, n);
    chk("gap_bad", gap_bad, 0);
  endtask
  task automatic rej(input logic [23:0] a, input logic [8:0] n);
    starts = 0;
    pops = 0;
    @(negedge sys_clk);
    addr = a;
    len = n;
    req = 1'b1;
    @(negedge sys_clk);
    req = 1'b0;
    chk("rej_done", done, 1);
    chk("rej_err", err, 1);
    chk("rej_busy", busy, 0);
    repeat (10) @(negedge sys_clk);
    chk("rej_starts", starts, 0);
    chk("rej_pops", pops, 0);
  endtask
  initial begin
    logic [23:0] ra;
    int rl, t;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge sys_clk);
    chk("reset_outs", {wr_data_rd, busy, done, err, spi_start, spi_end, data_send}, 0);
    sys_rst = 1'b0;
    run_req(24'h101010, 9'd4, 0);
    run_req(24'hABCD00, 9'd256, 0);
    rej(24'h0000F0, 9'd17);
    rej(24'h000000, 9'd0);
    rej(24'h000000, 9'd300);
    rej(24'h0000FF, 9'd2);
    run_req(24'h0000FF, 9'd1, 0);
    run_req(24'h123400, 9'd8, 3);
    nwip = 0;
    pops = 0;
    @(negedge sys_clk);
    addr = 24'h000200;
    len = 9'd8;
    req = 1'b1;
    @(negedge sys_clk);
    req = 1'b0;
    for (t = 0; t < 2000 && pops < 2; t++) @(negedge sys_clk);
    chk("rst_reach_data", pops >= 2, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("rst_outs", {wr_data_rd, busy, done, err, spi_start, spi_end, data_send}, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    run_req(24'h0004E0, 9'd5, 1);
    for (int i = 0; i < 6; i++) begin
      rl = $urandom_range(1, 40);
      ra = 24'($urandom);
      ra[7:0] = 8'($urandom_range(0, 256 - rl));
      run_req(ra, 9'(rl), $urandom_range(0, 2));
    end
`ifdef SPI_SEQ_TIMEOUT_EN
    run_req(24'h050000, 9'd4, 100);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_flash_wr_seq.md
SPI_FLASH_WR_SEQ -- requirements
Module: spi_flash_wr_seq

Interface
REQ-001 Parameter CS_GAP, default 4: minimum sys_clk cycles between spi_end and the next spi_start.
REQ-002 Parameter POLL_MAX, default 16'hFFFF: maximum RDSR polls before timeout (used only with SPI_SEQ_TIMEOUT_EN).
REQ-003 sys_clk  in  1  system clock, 50 MHz; the only clock.
REQ-004 sys_rst  in  1  reset; synchronous, active-high.
REQ-005 req  in  1  single-cycle start request; sampled only in IDLE.
REQ-006 addr  in  24  flash byte address, {sector,page,byte}; captured with req.
REQ-007 len  in  9  byte count, legal range 1..256; captured with req.
REQ-008 wr_data  in  8  program data, valid whenever wr_data_rd is high (show-ahead source).
REQ-009 wr_data_rd  out  1  one-cycle pop strobe; wr_data is consumed in the same cycle.
REQ-010 busy  out  1  high from the cycle after an accepted req until done.
REQ-011 done  out  1  one-cycle pulse at completion, including rejected requests.
REQ-012 err  out  1  valid with done: 1 means rejected or timed out.
REQ-013 spi_start  out  1  one-cycle pulse to spi_drive; opens a CS-low transaction.
REQ-014 spi_end  out  1  one-cycle pulse to spi_drive; closes the transaction.
REQ-015 data_send  out  8  byte to spi_drive; registered, held until the matching send_done.
REQ-016 send_done  in  1  spi_drive pulse: current data_send byte has been shifted out.
REQ-017 data_rec  in  8  byte from spi_drive, valid while rec_done is high.
REQ-018 rec_done  in  1  spi_drive pulse: one byte has been received.

Function
REQ-019 States: IDLE, WREN, GAP_A, PROG, GAP_B, RDSR, GAP_C, FIN.
REQ-020 In IDLE, req with len==0, len>256, or addr[7:0]+len>256 (page crossing) produces done=1, err=1 on the next cycle; there is no SPI activity and busy stays 0.
REQ-021 A legal req latches addr and len, sets busy, and enters WREN.
REQ-022 Each transaction: spi_start is pulsed with data_send already holding the first byte; on each send_done, data_send loads the next byte on the following clock.
REQ-023 On send_done of the last byte, spi_end is pulsed on the following clock.
REQ-024 WREN sends the single byte 8'h06.
REQ-025 GAP_A, GAP_B and GAP_C each wait exactly CS_GAP cycles after spi_end before the next state.
REQ-026 PROG sends 8'h02, addr[23:16], addr[15:8], addr[7:0], then len data bytes.
REQ-027 For each data byte, wr_data_rd pulses on the cycle data_send is loaded from wr_data: first with the cycle after the send_done of addr[7:0], then after each data-byte send_done except the last.
REQ-028 Exactly len wr_data_rd pulses occur per accepted request.
REQ-029 A 9-bit byte counter tracks data bytes; len==256 is handled without overflow.
REQ-030 RDSR sends 8'h05 then dummy 8'h00; data_rec is captured on the second rec_done of the transaction.
REQ-031 After GAP_C: if the captured status bit0 (WIP) is 1, go back to RDSR; if it is 0, go to FIN.
REQ-032 FIN pulses done with err=0, clears busy, and returns to IDLE in the same cycle.
REQ-033 req while busy is ignored and is not queued.
REQ-034 send_done or rec_done arriving in IDLE or in a GAP state is ignored.

Reset
REQ-035 sys_rst=1 at a clock edge forces IDLE and clears all outputs to 0, including data_send=8'h00, counters and the captured status.
REQ-036 Reset mid-transaction does not emit spi_end; spi_drive shares sys_rst, so the bus is abandoned cleanly.

Configuration
REQ-037 With SPI_SEQ_TIMEOUT_EN defined: RDSR poll count is incremented per RDSR transaction; reaching POLL_MAX with WIP still 1 gives FIN with done=1, err=1.
REQ-038 Without SPI_SEQ_TIMEOUT_EN: polling is unbounded, err is only driven by REQ-020, and no poll counter is synthesised.

Verification
REQ-039 Bench: req, addr=24'h101010, len=4, flash model WIP=0 on first poll -> bytes 06 | 02 10 10 10 D0 D1 D2 D3 | 05 00, four wr_data_rd pulses, done=1, err=0.
REQ-040 Bench: len=256, addr[7:0]=8'h00 -> 260 bytes in the PROG transaction, 256 wr_data_rd pulses, no page-cross error.
REQ-041 Bench: addr[7:0]=8'hF0, len=17 -> done=1, err=1 one cycle after req; spi_start never asserts.
REQ-042 Bench: WIP=1 for 3 polls, then 0 -> four RDSR transactions, each separated from the previous spi_end by at least CS_GAP cycles, then done.
REQ-043 Bench: sys_rst asserted during the PROG data phase -> next cycle all outputs 0, state IDLE; a new req then completes normally.
REQ-044 Bench (SPI_SEQ_TIMEOUT_EN, POLL_MAX=3): WIP stuck at 1 -> exactly 3 RDSR transactions, then done=1, err=1.
